prio_intr_ctrl: RTL

// - Parametrised, clocked successor to the c432 27-channel priority interrupt decoder: NUM_LVL priority buses x NUM_CH channels.
// - Latches interrupt edges into pending bits and applies a per-channel enable mask.
// - Arbitrates the highest-priority eligible source and presents it to the CPU with a valid/ack handshake.
// - Holds in-service until end-of-interrupt; sits between peripheral IRQ lines and the core interrupt port.

---
 rtl/intr_pkg.sv | 14 +
 rtl/prio_find_first.sv | 33 +++
 rtl/prio_intr_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared types and helpers for the priority interrupt controller family.
// Bit layout of every per-source vector is level-major: bit = lvl*num_ch + ch.
package intr_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SERV} intr_state_e;

  localparam int DEF_NUM_CH  = 9;
  localparam int DEF_NUM_LVL = 3;

  function automatic int lvl_ch_to_bit(input int lvl, input int ch, input int num_ch);
    return lvl * num_ch + ch;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational find-first over a level-major eligible vector.
// Lowest level wins, then lowest channel within that level.
module prio_find_first
  import intr_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int NUM_LVL = DEF_NUM_LVL,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int LVL_W  = $clog2(NUM_LVL)
) (
  input  logic [NUM_LVL*NUM_CH-1:0] elig,
  output logic                      any,
  output logic [LVL_W-1:0]          lvl,
  output logic [CH_W-1:0]           ch
);

  // Scan from the top down so the last hit written is the highest-priority one.
  always_comb begin
    any = 1'b0;
    lvl = '0;
    ch  = '0;
    for (int l = NUM_LVL - 1; l >= 0; l--) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (elig[lvl_ch_to_bit(l, c, NUM_CH)]) begin
          any = 1'b1;
          lvl = LVL_W'(l);
          ch  = CH_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/prio_intr_ctrl.sv
// Clocked priority interrupt controller: edge-latched pending bits, enable mask,
// find-first arbitration and a valid/ack + end-of-interrupt handshake to the CPU.
module prio_intr_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int NUM_LVL = DEF_NUM_LVL,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int LVL_W  = $clog2(NUM_LVL),
  localparam int NB     = NUM_LVL * NUM_CH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NB-1:0]    irq_i,
  input  logic [NUM_CH-1:0] en_i,
  output logic             irq_valid_o,
  output logic [LVL_W-1:0] irq_lvl_o,
  output logic [CH_W-1:0]  irq_ch_o,
  input  logic             irq_ack_i,
  input  logic             eoi_i,
  output logic             busy_o,
  output logic [NB-1:0]    pend_o
);

  intr_state_e      state_reg, state_next;
  logic [NB-1:0]    irq_prev_reg;
  logic [NB-1:0]    pend_reg;
  logic [NB-1:0]    rise;
  logic [NB-1:0]    clr;
  logic [NB-1:0]    elig;
  logic             win_any;
  logic [LVL_W-1:0] win_lvl;
  logic [CH_W-1:0]  win_ch;
  logic             ack_take;

  assign rise     = irq_i & ~irq_prev_reg;
  assign elig     = pend_reg & {NUM_LVL{en_i}};
  assign ack_take = (state_reg == REQ) && irq_ack_i;

  // Clear targets the committed grant, not the live winner.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : gen_clr
      assign clr[gi] = ack_take &&
                       (lvl_ch_to_bit(int'(irq_lvl_o), int'(irq_ch_o), NUM_CH) == gi);
    end
  endgenerate

  prio_find_first #(
    .NUM_CH  (NUM_CH),
    .NUM_LVL (NUM_LVL)
  ) u_find_first (
    .elig (elig),
    .any  (win_any),
    .lvl  (win_lvl),
    .ch   (win_ch)
  );

  // A new edge coinciding with the clear re-arms the source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_reg <= '0;
      pend_reg     <= '0;
    end else begin
      irq_prev_reg <= irq_i;
      pend_reg     <= (pend_reg & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (win_any)   state_next = REQ;
      REQ:     if (irq_ack_i) state_next = SERV;
      SERV:    if (eoi_i)     state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_valid_o <= 1'b0;
      irq_lvl_o   <= '0;
      irq_ch_o    <= '0;
    end else if ((state_reg == IDLE) && win_any) begin
      irq_valid_o <= 1'b1;
      irq_lvl_o   <= win_lvl;
      irq_ch_o    <= win_ch;
    end else if (ack_take) begin
      irq_valid_o <= 1'b0;
    end
  end

  assign busy_o = (state_reg != IDLE);
  assign pend_o = pend_reg;

endmodule
